// File: rtl/barrel_line_fetch_sched.sv
// Per-scanline barrel sprite scheduler: scans the object table during hblank, then
// streams the selected sprite rows from one shared ROM port into the line buffer.
module barrel_line_fetch_sched #(
  parameter int N_OBJ   = 8,
  parameter int MAX_HIT = 4,
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int ROM_AW  = 8,
  parameter int PIX_W   = 4,
  parameter int H_ACT   = 640
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic                line_start,
  input  logic [9:0]          next_y,
  input  logic [N_OBJ-1:0]    obj_en,
  input  logic [10*N_OBJ-1:0] obj_x,
  input  logic [10*N_OBJ-1:0] obj_y,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [PIX_W-1:0]    rom_q,
  output logic                lb_we,
  output logic [9:0]          lb_addr,
  output logic [PIX_W-1:0]    lb_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                overrun,
  output logic [2:0]          state_dbg
);
  localparam int IW = $clog2(N_OBJ);
  localparam int CW = $clog2(MAX_HIT + 1);
  localparam int EW = $clog2(MAX_HIT);
  localparam int RW = $clog2(SPR_H);
  localparam int XW = $clog2(SPR_W);

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]    ny;
  logic [IW-1:0] scan_idx;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] hit_row [MAX_HIT];
  logic [9:0]    hit_x   [MAX_HIT];
  logic [EW-1:0] cur_ent;
  logic [XW-1:0] cur_col;

  logic [9:0]    cur_y, cur_x;
  logic          obj_hit, store, iss_go;
  logic [RW-1:0] obj_row;
  logic [EW-1:0] nxt_ent;
  logic [XW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic [9:0]    nxt_x;
  logic          iss_vld, dat_vld;
  logic [10:0]   iss_xpos, dat_xpos;

  assign cur_y   = obj_y[10*int'(scan_idx) +: 10];
  assign cur_x   = obj_x[10*int'(scan_idx) +: 10];
  assign obj_hit = obj_en[scan_idx] && (ny >= cur_y) &&
                   ({1'b0, ny} < ({1'b0, cur_y} + 11'(SPR_H)));
  assign obj_row = RW'(ny - cur_y);
  assign store   = (state == SCAN) && obj_hit && (cnt < CW'(MAX_HIT));
  assign cnt_nxt = cnt + CW'(store);

  // Next ROM issue. The first issue leaves SCAN directly so the fetch has no bubble;
  // it forwards the entry being stored on the last scan cycle.
  always_comb begin
    iss_go  = 1'b0;
    nxt_ent = cur_ent;
    nxt_col = '0;
    nxt_row = hit_row[cur_ent];
    nxt_x   = hit_x[cur_ent];
    if (state == SCAN && scan_idx == IW'(N_OBJ - 1) && cnt_nxt != '0) begin
      iss_go  = 1'b1;
      nxt_ent = EW'(cnt_nxt - 1'b1);
      if (store) begin
        nxt_row = obj_row;
        nxt_x   = cur_x;
      end else begin
        nxt_row = hit_row[nxt_ent];
        nxt_x   = hit_x[nxt_ent];
      end
    end else if (state == FETCH) begin
      if (cur_col != XW'(SPR_W - 1)) begin
        iss_go  = 1'b1;
        nxt_col = cur_col + 1'b1;
      end else if (cur_ent != '0) begin
        iss_go  = 1'b1;
        nxt_ent = cur_ent - 1'b1;
        nxt_row = hit_row[nxt_ent];
        nxt_x   = hit_x[nxt_ent];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_start) state_nxt = SCAN;
      SCAN:    if (scan_idx == IW'(N_OBJ - 1)) state_nxt = (cnt_nxt == '0) ? DONE : FETCH;
      FETCH:   if (!iss_go) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ny       <= '0;
      scan_idx <= '0;
      cnt      <= '0;
      cur_ent  <= '0;
      cur_col  <= '0;
      rom_addr <= '0;
      iss_vld  <= 1'b0;
      iss_xpos <= '0;
      dat_vld  <= 1'b0;
      dat_xpos <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      overrun  <= 1'b0;
      for (int k = 0; k < MAX_HIT; k++) begin
        hit_row[k] <= '0;
        hit_x[k]   <= '0;
      end
    end else begin
      done     <= (state == DONE);
      overrun  <= line_start && (state != IDLE);
      iss_vld  <= iss_go;
      dat_vld  <= iss_vld;
      dat_xpos <= iss_xpos;
      if (state == IDLE && line_start) begin
        ny       <= next_y;
        cnt      <= '0;
        overflow <= 1'b0;
        scan_idx <= '0;
        busy     <= 1'b1;
      end
      if (state == DONE) busy <= 1'b0;
      if (state == SCAN) begin
        scan_idx <= scan_idx + 1'b1;
        cnt      <= cnt_nxt;
        if (store) begin
          hit_row[cnt[EW-1:0]] <= obj_row;
          hit_x[cnt[EW-1:0]]   <= cur_x;
        end
        if (obj_hit && !store) overflow <= 1'b1;
      end
      if (iss_go) begin
        rom_addr <= {nxt_row, nxt_col};
        iss_xpos <= {1'b0, nxt_x} + 11'(nxt_col);
        cur_ent  <= nxt_ent;
        cur_col  <= nxt_col;
      end
    end
  end

  // ROM data arrives the cycle after the address, paired with the delayed x position.
  assign lb_we     = dat_vld && (rom_q != '0) && (dat_xpos < 11'(H_ACT));
  assign lb_addr   = dat_xpos[9:0];
  assign lb_data   = dat_vld ? rom_q : '0;
  assign state_dbg = state;
endmodule

// File: doc/barrel_line_fetch_sched.md
Name: barrel_line_fetch_sched

Overview:
- Per-scanline scheduler that shares one barrel sprite ROM read port among up to N_OBJ barrel objects.
- On each hblank line_start it scans the object table and selects objects that intersect the next scanline.
- It then sequences ROM reads for those rows and writes the opaque palette indices into the line buffer.
- The line buffer is read during the following active line by the pixel mux; palette lookup stays downstream.

Parameters:
- N_OBJ, 8, number of barrel object slots.
- MAX_HIT, 4, max objects fetched per line; extra hits are dropped.
- SPR_W, 16, sprite width in pixels (power of 2).
- SPR_H, 16, sprite height in rows (power of 2).
- ROM_AW, 8, ROM address width = log2(SPR_W*SPR_H).
- PIX_W, 4, palette index width; index 0 is transparent.
- H_ACT, 640, visible width; used as the clip limit.

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse at start of hblank.
- next_y  in  10  scanline to prepare; sampled when line_start=1.
- obj_en  in  N_OBJ  per-object enable.
- obj_x  in  10*N_OBJ  object left edge; slot i occupies bits [10i+9:10i].
- obj_y  in  10*N_OBJ  object top edge; same packing as obj_x.
- rom_addr  out  ROM_AW  ROM address, registered.
- rom_q  in  PIX_W  ROM data; valid exactly 1 cycle after rom_addr.
- lb_we  out  1  line-buffer write enable.
- lb_addr  out  10  line-buffer x address.
- lb_data  out  PIX_W  palette index to write.
- busy  out  1  high from the cycle after an accepted line_start until the done pulse.
- done  out  1  one-cycle pulse when the line is complete.
- overflow  out  1  registered; set for the current line if hits exceed MAX_HIT; cleared on the next accepted line_start.
- overrun  out  1  one-cycle pulse when line_start arrives while busy.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. rom_addr, lb_we, lb_addr, lb_data, busy, done, overflow and overrun are all 0. Hit list is cleared.
- IDLE: when line_start=1, latch next_y, clear the hit count and overflow, then go to SCAN. busy=1 from the next cycle.
- SCAN: examine one object per cycle in ascending index 0..N_OBJ-1 (N_OBJ cycles).
  - Hit condition: obj_en[i] && next_y >= obj_y[i] && next_y < obj_y[i]+SPR_H. The sum is computed in 11 bits, so there is no wrap near y=1023.
  - On a hit with count<MAX_HIT: store index i and row = next_y - obj_y[i] (log2(SPR_H) bits), then increment count.
  - On a hit with count==MAX_HIT: set overflow and do not store.
  - After the last object: if count==0 go to DONE, else go to FETCH.
- FETCH: walk the hit list from the last stored entry down to entry 0, so the lowest object index is written last and wins overlaps.
  - For each entry, col steps 0..SPR_W-1, one per cycle. Drive rom_addr = row*SPR_W + col.
  - Issue rate is one ROM read per cycle with no bubbles between objects, so FETCH lasts count*SPR_W cycles.
- Data pipeline: the cycle after each issue, rom_q pairs with the delayed xpos = obj_x + col (11-bit sum).
  - lb_we=1 only if rom_q != 0 and xpos < H_ACT.
  - lb_addr = xpos[9:0]; lb_data = rom_q.
  - Transparent or clipped pixels produce lb_we=0.
- DRAIN: one cycle after the last issue to complete the final write, then go to DONE.
- DONE: done=1 for one cycle, busy goes low in the same cycle, then return to IDLE.
- Latency: done is asserted 1 + N_OBJ + count*SPR_W + 1 cycles after line_start (+1 more if count>0).
  - Default worst case is 1+8+64+1+1 = 75 cycles, within the 160-cycle hblank.
- line_start while busy (SCAN/FETCH/DRAIN/DONE): ignored, the current line continues, and overrun pulses for 1 cycle.
- Object inputs are sampled live during SCAN. The producer must hold them stable from line_start through SCAN.
- rom_addr holds its last value outside FETCH. lb_we=0 outside the data pipeline.
- Reset asserted mid-FETCH: outputs go to 0 immediately (async) and no further writes occur. After release the block waits in IDLE for a fresh line_start.

Test Plan:
- Single object: slot0 en, x=100, y=50; line_start with next_y=53.
  - Expect rom_addr sequence 48..63.
  - Expect writes only at lb_addr 100..115 where ROM is nonzero.
  - done arrives 1+8+16+1+1=27 cycles after line_start.
- Miss/edge rows: next_y=49, then 66 → no writes, done after 10 cycles. next_y=65 → row 15, rom_addr 240..255.
- Overlap priority: slot0 x=200 and slot3 x=205, both hitting.
  - Slot3 is fetched first, slot0 second.
  - Overlapping lb_addr 205..215 receive slot0 data last.
- Overflow: 6 enabled objects all hitting → only slots 0..3 are fetched (64 issues) and overflow=1. The next line with 1 hit clears overflow.
- Clip: x=630 → writes only for lb_addr 630..639. Cols 10..15 give lb_we=0, and no address wraps to 0..5.
- Overrun and reset: line_start during FETCH → single overrun pulse, current line completes normally. reset_n low mid-FETCH → lb_we=0 and busy=0 immediately, IDLE after release.
